// File: rtl/mult_div_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : mult_div_sequencer
// Description : Iterative signed MULT/DIV engine with one shared adder/subtractor
//               and its sequencer; commits results to the HI/LO registers.
// Revision    : 1.0 - initial release
// ============================================================================
module mult_div_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int            c_CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MULT = 3'd1,
    S_DIV  = 3'd2,
    S_FIX  = 3'd3,
    S_ZERO = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t r_state;
  state_t w_next;

  logic                 r_op;
  logic                 r_sa;
  logic                 r_sb;
  logic                 r_zero;
  logic [WIDTH-1:0]     r_amag;
  logic [WIDTH-1:0]     r_bmag;
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;
  logic [c_CNT_W-1:0]   r_cnt;
  // {upper/remainder (WIDTH+1 bits), lower/quotient (WIDTH bits)}
  logic [2*WIDTH:0]     r_work;

  logic [WIDTH-1:0]     w_amag;
  logic [WIDTH-1:0]     w_bmag;
  logic [WIDTH:0]       w_lhs;
  logic [WIDTH:0]       w_rhs;
  logic                 w_cin;
  logic [WIDTH+1:0]     w_sum;
  logic [WIDTH:0]       w_rem_next;
  logic [2*WIDTH-1:0]   w_prod;
  logic [2*WIDTH-1:0]   w_prod_fix;
  logic [WIDTH-1:0]     w_quo_fix;
  logic [WIDTH-1:0]     w_rem_fix;

  // Two's-complement negation of the most negative value yields the correct
  // unsigned magnitude 2^(WIDTH-1).
  assign w_amag = a[WIDTH-1] ? (~a + 1'b1) : a;
  assign w_bmag = b[WIDTH-1] ? (~b + 1'b1) : b;

  // Shared adder: multiply adds the multiplicand, divide subtracts the divisor
  // from the shifted partial remainder (carry-out high means no borrow).
  always_comb begin
    if (r_op) begin
      w_lhs = r_work[2*WIDTH-1:WIDTH-1];
      w_rhs = ~{1'b0, r_bmag};
      w_cin = 1'b1;
    end else begin
      w_lhs = r_work[2*WIDTH:WIDTH];
      w_rhs = r_work[0] ? {1'b0, r_amag} : '0;
      w_cin = 1'b0;
    end
  end

  assign w_sum      = {1'b0, w_lhs} + {1'b0, w_rhs} + {{(WIDTH+1){1'b0}}, w_cin};
  assign w_rem_next = w_sum[WIDTH+1] ? w_sum[WIDTH:0] : w_lhs;

  assign w_prod     = r_work[2*WIDTH-1:0];
  assign w_prod_fix = (r_sa ^ r_sb) ? (~w_prod + 1'b1) : w_prod;
  assign w_quo_fix  = (r_sa ^ r_sb) ? (~r_work[WIDTH-1:0] + 1'b1) : r_work[WIDTH-1:0];
  assign w_rem_fix  = r_sa ? (~r_work[2*WIDTH-1:WIDTH] + 1'b1) : r_work[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (op && (b == '0)) begin
            w_next = S_ZERO;
          end else if (op) begin
            w_next = S_DIV;
          end else begin
            w_next = S_MULT;
          end
        end
      end
      S_MULT:  if (r_cnt == c_LAST) w_next = S_FIX;
      S_DIV:   if (r_cnt == c_LAST) w_next = S_FIX;
      S_FIX:   w_next = S_DONE;
      S_ZERO:  w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_op   <= 1'b0;
      r_sa   <= 1'b0;
      r_sb   <= 1'b0;
      r_zero <= 1'b0;
      r_amag <= '0;
      r_bmag <= '0;
      r_cnt  <= '0;
      r_work <= '0;
      r_hi   <= '0;
      r_lo   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op   <= op;
            r_sa   <= a[WIDTH-1];
            r_sb   <= b[WIDTH-1];
            r_zero <= op && (b == '0);
            r_amag <= w_amag;
            r_bmag <= w_bmag;
            r_cnt  <= '0;
            r_work <= {{(WIDTH+1){1'b0}}, (op ? w_amag : w_bmag)};
          end
        end
        S_MULT: begin
          r_work <= {1'b0, w_sum[WIDTH:0], r_work[WIDTH-1:1]};
          r_cnt  <= r_cnt + c_CNT_W'(1);
        end
        S_DIV: begin
          r_work <= {w_rem_next, r_work[WIDTH-2:0], w_sum[WIDTH+1]};
          r_cnt  <= r_cnt + c_CNT_W'(1);
        end
        S_FIX: begin
          if (r_op) begin
            r_hi <= w_rem_fix;
            r_lo <= w_quo_fix;
          end else begin
            r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
            r_lo <= w_prod_fix[WIDTH-1:0];
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy     = (r_state != S_IDLE);
  assign done     = (r_state == S_DONE);
  assign div_zero = (r_state == S_DONE) && r_zero;
  assign hi       = r_hi;
  assign lo       = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mult_div_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult_div_sequencer
// Description : Self-checking bench for mult_div_sequencer (WIDTH = 32).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_div_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic        op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  mult_div_sequencer #(.WIDTH(32)) u_dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi       (hi),
    .lo       (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          lat;
  } exp_t;

  vec_t        vecs[11];
  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic void model(input logic iop, input logic [31:0] ia, input logic [31:0] ib,
                                output logic [31:0] ohi, output logic [31:0] olo);
    logic signed [63:0] sa, sbv, p, q, r;
    sa  = {{32{ia[31]}}, ia};
    sbv = {{32{ib[31]}}, ib};
    if (!iop) begin
      p   = sa * sbv;
      ohi = p[63:32];
      olo = p[31:0];
    end else begin
      q   = sa / sbv;
      r   = sa % sbv;
      ohi = r[31:0];
      olo = q[31:0];
    end
  endfunction

  // Issue one operation from an IDLE cycle and wait for its done pulse.
  task automatic do_op(input logic iop, input logic [31:0] ia, input logic [31:0] ib,
                       input logic [31:0] ehi, input logic [31:0] elo, input logic edz,
                       input int elat, input logic intf, input logic start_in_done);
    exp_t e;
    exp_t g;
    int   n;
    @(negedge clk);
    check("done_low_in_idle", done, 1'b0);
    start = 1'b1; op = iop; a = ia; b = ib;
    e.hi = ehi; e.lo = elo; e.dz = edz; e.lat = elat;
    sb_q.push_back(e);
    m_hi = ehi; m_lo = elo;
    @(negedge clk);
    start = 1'b0; op = $urandom_range(0, 1); a = $urandom; b = $urandom;
    n = 1;
    check("busy_after_start", busy, 1'b1);
    while (done !== 1'b1 && n < 300) begin
      if (intf && n == 10) begin
        start = 1'b1; op = 1'b1; a = 32'd55; b = 32'd0;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    check("done_seen", done, 1'b1);
    if (sb_q.size() == 0) begin
      check("scoreboard_nonempty", 64'd0, 64'd1);
    end else begin
      g = sb_q.pop_front();
      check("latency", 64'(n), 64'(g.lat));
      check("hi", hi, g.hi);
      check("lo", lo, g.lo);
      check("div_zero", div_zero, g.dz);
    end
    if (start_in_done) begin
      start = 1'b1; op = 1'b0; a = 32'h1111_1111; b = 32'h2222_2222;
    end
  endtask

  initial begin
    logic [31:0] rhi, rlo, ra, rb;
    logic        rop;
    bit          seen_done;

    vecs[0]  = '{1'b0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[1]  = '{1'b0, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[2]  = '{1'b1, 32'hFFFF_FFEF,  32'd5,         32'hFFFF_FFFE, 32'hFFFF_FFFD};
    vecs[3]  = '{1'b1, 32'd100,        32'd7,         32'd2,         32'd14};
    vecs[4]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         32'h8000_0000};
    vecs[5]  = '{1'b0, 32'h1234_5678,  32'd0,         32'd0,         32'd0};
    vecs[6]  = '{1'b1, 32'd17,         32'hFFFF_FFFB, 32'd2,         32'hFFFF_FFFD};
    vecs[7]  = '{1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'd0,         32'd1};
    vecs[8]  = '{1'b1, 32'd7,          32'd100,       32'd7,         32'd0};
    vecs[9]  = '{1'b0, 32'h7FFF_FFFF,  32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001};
    vecs[10] = '{1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd14};

    reset = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_div_zero", div_zero, 1'b0);
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 11; i++) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, 1'b0, 34, 1'b0, 1'b0);
    end

    // Divide by zero keeps HI/LO from the previous operation.
    do_op(1'b1, 32'd123, 32'd0, m_hi, m_lo, 1'b1, 2, 1'b0, 1'b0);

    // Start pulse mid-MULT and during DONE are ignored; back-to-back accepted.
    do_op(1'b0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 34, 1'b1, 1'b1);
    do_op(1'b1, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 34, 1'b0, 1'b0);

    for (int i = 0; i < 6; i++) begin
      rop = 1'(i % 2);
      ra  = $urandom;
      rb  = $urandom;
      if (rop && rb == 32'd0) rb = 32'd3;
      model(rop, ra, rb, rhi, rlo);
      do_op(rop, ra, rb, rhi, rlo, 1'b0, 34, 1'b0, 1'b0);
    end

    repeat (5) @(negedge clk);
    check("hold_hi", hi, m_hi);
    check("hold_lo", lo, m_lo);

    // Asynchronous reset in the middle of a DIV.
    @(negedge clk);
    start = 1'b1; op = 1'b1; a = 32'd1000; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("async_reset_busy", busy, 1'b0);
    check("async_reset_done", done, 1'b0);
    check("async_reset_hi", hi, 32'd0);
    check("async_reset_lo", lo, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen_done = 1'b1;
    end
    check("idle_after_reset", busy, 1'b0);
    check("no_done_after_abort", 64'(seen_done), 64'd0);
    check("scoreboard_drained", 64'(sb_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
